// File: rtl/pwm_audio_dac.sv
// Audio output stage: sample-clock divider, volume/mute processing, soft-start ramp
// and a glitch-free single-bit PWM driver for the mono jack.
module pwm_audio_dac #(
  parameter int CLK_HZ    = 100000000,
  parameter int SAMPLE_HZ = 8000,
  parameter int PWM_BITS  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PWM_BITS-1:0] sample_in,
  input  logic [1:0]          volume,
  input  logic                mute,
  output logic                sample_clk,
  output logic                sample_strobe,
  output logic                pwm_out,
  output logic                amp_en,
  output logic [0:0]          state_dbg
);

  localparam int DIV = CLK_HZ / SAMPLE_HZ;
  localparam int DW  = $clog2(DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(DIV / 2);
  localparam int W = PWM_BITS;
  localparam logic [W-1:0] MID = {1'b1, {(W-1){1'b0}}};

  localparam logic [0:0] ST_RAMP = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          sample_clk_q, sample_clk_d;
  logic          sample_strobe_q, sample_strobe_d;
  logic [W-1:0]  level_q, level_d;
  logic [0:0]    state_q, state_d;
  logic          amp_en_q, amp_en_d;
  logic [W-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic [W-1:0]  duty_q, duty_d;
  logic          pwm_out_q, pwm_out_d;

  logic signed [W:0] dev;
  logic signed [W:0] shifted;
  logic [W-1:0]      proc;

  // Attenuate the signed deviation from mid-scale, then re-bias to offset binary.
  always_comb begin
    dev     = $signed({1'b0, sample_in}) - $signed({1'b0, MID});
    shifted = dev >>> volume;
    proc    = shifted[W-1:0] + MID;
    if (mute) begin
      proc = MID;
    end
  end

  always_comb begin
    div_cnt_d       = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    sample_clk_d    = (div_cnt_q < DIV_HALF);
    sample_strobe_d = (div_cnt_q == DIV_LAST);

    level_d = level_q;
    state_d = state_q;
    if (sample_strobe_q) begin
      if (state_q == ST_RAMP) begin
        level_d = level_q + 1'b1;
        if (level_d == MID) begin
          state_d = ST_RUN;
        end
      end else begin
        level_d = proc;
      end
    end

    amp_en_d  = 1'b1;
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    // Duty is only reloaded on the last count so each frame is built from one value.
    duty_d    = (pwm_cnt_q == '1) ? level_q : duty_q;
    pwm_out_d = (pwm_cnt_q < duty_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q       <= '0;
      sample_clk_q    <= 1'b0;
      sample_strobe_q <= 1'b0;
      level_q         <= '0;
      state_q         <= ST_RAMP;
      amp_en_q        <= 1'b0;
      pwm_cnt_q       <= '0;
      duty_q          <= '0;
      pwm_out_q       <= 1'b0;
    end else begin
      div_cnt_q       <= div_cnt_d;
      sample_clk_q    <= sample_clk_d;
      sample_strobe_q <= sample_strobe_d;
      level_q         <= level_d;
      state_q         <= state_d;
      amp_en_q        <= amp_en_d;
      pwm_cnt_q       <= pwm_cnt_d;
      duty_q          <= duty_d;
      pwm_out_q       <= pwm_out_d;
    end
  end

  assign sample_clk    = sample_clk_q;
  assign sample_strobe = sample_strobe_q;
  assign pwm_out       = pwm_out_q;
  assign amp_en        = amp_en_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_pwm_audio_dac.sv
// Bench for pwm_audio_dac with DIV=256, so every sample period is exactly one PWM frame.
module tb_pwm_audio_dac;

  localparam int CLK_HZ    = 2560;
  localparam int SAMPLE_HZ = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] sample_in = 8'hFF;
  logic [1:0] volume = 2'd0;
  logic       mute = 1'b0;
  logic       sample_clk, sample_strobe, pwm_out, amp_en;
  logic [0:0] state_dbg;

  always #5 clk = ~clk;

  pwm_audio_dac #(.CLK_HZ(CLK_HZ), .SAMPLE_HZ(SAMPLE_HZ), .PWM_BITS(8)) dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .volume(volume), .mute(mute),
    .sample_clk(sample_clk), .sample_strobe(sample_strobe), .pwm_out(pwm_out),
    .amp_en(amp_en), .state_dbg(state_dbg)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Scoreboard: expected duty per PWM frame, pushed at each sample period end.
  logic [7:0] exp_q[$];
  logic [7:0] cur_exp = 8'h00;
  logic [7:0] m_level = 8'h00;
  bit         m_ramp = 1'b1;
  bit         mon_active = 1'b0;
  int ph = 0;
  int frame_cnt = 0;
  int strobe_cnt = 0;
  int last_high = 0;
  int pwm_bad = 0;
  int tim_bad = 0;
  int high_cnt = 0;

  typedef struct {
    logic [7:0] s;
    logic [1:0] v;
    logic       m;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[11];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_proc(input logic [7:0] s, input logic [1:0] v,
                                            input logic m);
    int dv;
    if (m) return 8'h80;
    dv = int'(s) - 128;
    dv = dv >>> v;
    return 8'(dv + 128);
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out waiting, got no event expected one", name);
  endtask

  task automatic wait_frames(input int n);
    int target = frame_cnt + n;
    int budget = n * 256 + 300;
    while (frame_cnt < target && budget > 0) begin
      tick();
      budget--;
    end
    if (frame_cnt < target) timeout("wait_frames");
  endtask

  task automatic wait_strobes(input int n);
    int budget = 140 * 256;
    while (strobe_cnt < n && budget > 0) begin
      tick();
      budget--;
    end
    if (strobe_cnt < n) timeout("wait_strobes");
  endtask

  task automatic wait_ph(input int p);
    int budget = 600;
    while (ph != p && budget > 0) begin
      tick();
      budget--;
    end
    if (ph != p) timeout("wait_ph");
  endtask

  // Monitor: checks each output cycle against frame position and the expected duty.
  initial forever begin
    @(posedge clk);
    #1;
    if (reset) begin
      mon_active = 1'b0;
      exp_q.delete();
      strobe_cnt = 0;
    end else begin
      if (!mon_active) begin
        mon_active = 1'b1;
        ph = 0;
        m_level = 8'h00;
        m_ramp = 1'b1;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
      end
      if (ph == 0) begin
        if (exp_q.size() > 0) begin
          cur_exp = exp_q.pop_front();
        end else begin
          n_fail++;
          $display("FAIL scoreboard_empty: got empty queue expected an entry");
        end
        pwm_bad = 0;
        tim_bad = 0;
        high_cnt = 0;
      end
      if (pwm_out !== (ph < int'(cur_exp))) pwm_bad++;
      if (pwm_out === 1'b1) high_cnt++;
      if (sample_clk !== (ph < 128) || sample_strobe !== (ph == 255) || amp_en !== 1'b1)
        tim_bad++;
      if (sample_strobe === 1'b1) strobe_cnt++;
      if (ph == 255) begin
        check("pwm_frame_shape", pwm_bad, 0);
        check("pwm_frame_high", high_cnt, int'(cur_exp));
        check("frame_timing", tim_bad, 0);
        last_high = high_cnt;
        frame_cnt++;
        #3;
        if (m_ramp) begin
          m_level = m_level + 8'h01;
          if (m_level == 8'h80) m_ramp = 1'b0;
        end else begin
          m_level = model_proc(sample_in, volume, mute);
        end
        exp_q.push_back(m_level);
        ph = 0;
      end else begin
        ph++;
      end
    end
  end

  initial begin
    vecs[0]  = '{8'hFF, 2'd0, 1'b0, 8'hFF};
    vecs[1]  = '{8'h00, 2'd0, 1'b0, 8'h00};
    vecs[2]  = '{8'h00, 2'd1, 1'b0, 8'h40};
    vecs[3]  = '{8'h00, 2'd2, 1'b0, 8'h60};
    vecs[4]  = '{8'h00, 2'd3, 1'b0, 8'h70};
    vecs[5]  = '{8'hFF, 2'd1, 1'b0, 8'hBF};
    vecs[6]  = '{8'hE0, 2'd0, 1'b1, 8'h80};
    vecs[7]  = '{8'hE0, 2'd0, 1'b0, 8'hE0};
    vecs[8]  = '{8'h7F, 2'd3, 1'b0, 8'h7F};
    vecs[9]  = '{8'h81, 2'd3, 1'b0, 8'h80};
    vecs[10] = '{8'h3C, 2'd2, 1'b1, 8'h80};

    // Reset state
    repeat (4) tick();
    check("rst_sample_clk", sample_clk, 0);
    check("rst_strobe", sample_strobe, 0);
    check("rst_pwm_out", pwm_out, 0);
    check("rst_amp_en", amp_en, 0);
    check("rst_state", state_dbg, 0);

    reset = 1'b0;
    tick();
    check("rel_amp_en", amp_en, 1);
    check("rel_sample_clk", sample_clk, 1);

    // Soft start with full-scale input held
    wait_strobes(127);
    tick();
    check("ramp_state_127", state_dbg, 0);
    wait_strobes(128);
    tick();
    check("ramp_state_128", state_dbg, 1);
    wait_strobes(129);
    wait_frames(2);
    check("run_first_high", last_high, 255);

    for (int i = 0; i < 11; i++) begin
      sample_in = vecs[i].s;
      volume = vecs[i].v;
      mute = vecs[i].m;
      wait_frames(4);
      check($sformatf("vec%0d_high", i), last_high, int'(vecs[i].exp));
    end

    for (int i = 0; i < 3; i++) begin
      sample_in = 8'($urandom_range(0, 255));
      volume = 2'($urandom_range(0, 3));
      mute = 1'b0;
      wait_frames(3);
    end

    // Mute asserted one clk before a strobe, then released
    sample_in = 8'hE0;
    volume = 2'd0;
    mute = 1'b0;
    wait_frames(3);
    wait_ph(254);
    mute = 1'b1;
    wait_frames(3);
    check("mute_on_high", last_high, 128);
    wait_ph(254);
    mute = 1'b0;
    wait_frames(3);
    check("mute_off_high", last_high, 224);

    // Mute changing on the strobe cycle itself
    wait_ph(255);
    mute = 1'b1;
    wait_frames(3);
    check("mute_strobe_high", last_high, 128);
    mute = 1'b0;
    wait_frames(3);

    // Reset mid-run at div_cnt=37
    wait_ph(36);
    check("pre_rst_pwm_out", pwm_out, 1);
    reset = 1'b1;
    tick();
    check("mid_rst_sample_clk", sample_clk, 0);
    check("mid_rst_strobe", sample_strobe, 0);
    check("mid_rst_pwm_out", pwm_out, 0);
    check("mid_rst_amp_en", amp_en, 0);
    check("mid_rst_state", state_dbg, 0);
    repeat (3) tick();
    reset = 1'b0;
    wait_frames(3);
    check("reramp_first", last_high, 1);
    wait_frames(2);
    check("reramp_third", last_high, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
